decode_issue_queue: RTL and testbench
=====================================

// Module: decode_issue_queue
// PURPOSE
// - Parametrised in-order issue buffer between rename/decode and the execute pipes.
// - Holds up to p_depth renamed uops, each with two source pregs and a pending bit per source.
// - Pending bits clear on completion broadcasts (wakeup). The oldest entry issues once both
//   sources are ready.
// - A squash removes every entry younger than the squashing seq_num.
// PARAMETERS
// - p_depth          4   entries; power of 2, >= 2
// - p_uop_bits       32  opaque payload width (uop, pc, imm etc. packed by the producer)
// - p_seq_num_bits   8   sequence-number width; wraps modulo 2^p_seq_num_bits
// - p_phys_addr_bits 6   physical register address width
// PORTS
// - clk            in   1   clock
// - rst            in   1   reset; synchronous, active-high
// - enq_val        in   1   enqueue request
// - enq_rdy        out  1   queue can accept an entry
// - enq_payload    in   p_uop_bits         uop payload
// - enq_seq_num    in   p_seq_num_bits     sequence number
// - enq_psrc       in   2 x p_phys_addr_bits  source pregs [1:0]
// - enq_pend       in   2                  source still pending, per source
// - deq_val        out  1   head valid and ready to issue
// - deq_rdy        in   1   execute accepts
// - deq_payload, deq_seq_num, deq_psrc   out   head entry fields
// - cmp_val        in   1   completion broadcast valid
// - cmp_preg       in   p_phys_addr_bits   completing preg
// - sq_val         in   1   squash valid
// - sq_seq_num     in   p_seq_num_bits     squashing instruction
// - count          out  $clog2(p_depth)+1  number of occupied entries
// BEHAVIOUR
// - Reset: head = tail = 0, count = 0, all entry valid bits clear, deq_val = 0, enq_rdy = 1.
// - Storage: circular buffer with head/tail pointers and an extra wrap bit each.
// - Flags: full when the pointers are equal with differing wrap bits; empty when the
//   pointers are equal with equal wrap bits.
// - enq_rdy = !full.
//   - Depends on registered state only. No same-cycle enq/deq pass-through when full.
// - Enqueue fires on enq_val & enq_rdy. Entry written at tail; tail advances next cycle.
// - Latency: minimum 1 cycle from enqueue to deq_val. There is no enq-to-deq flow-through.
// - Wakeup: for every valid entry, pend[i] clears next cycle when cmp_val & (psrc[i] == cmp_preg).
// - Wakeup applies to an entry being enqueued in the same cycle: captured pend[i] = enq_pend[i]
//   & !(cmp_val & enq_psrc[i] == cmp_preg).
// - Issue: deq_val = !empty & !pend_eff[0] & !pend_eff[1] & !head_killed.
//   - Dequeue fires on deq_val & deq_rdy; head advances next cycle.
//   - deq_* fields always show the head entry (don't-care when empty).
// - Age rule: entry E is younger than S iff d = (E.seq - S) mod 2^p_seq_num_bits satisfies
//   d != 0 and d < 2^(p_seq_num_bits-1).
//   - The squashing instruction itself (d == 0) is not killed.
// - Squash: on sq_val, every valid entry younger than sq_seq_num is killed.
//   - Killed entries form a contiguous suffix. Tail is set to the oldest killed slot next cycle;
//     count updates accordingly.
//   - If the head itself is killed, deq_val = 0 that cycle.
// - Simultaneous enq + sq: the enqueue is dropped if enq_seq_num is younger than sq_seq_num,
//   otherwise it is written after the surviving entries.
// - Simultaneous deq + sq: the dequeue still completes when the head survives.
// - Simultaneous enq + deq: count is unchanged; legal at any occupancy except when full
//   (enq_rdy = 0).
// - Pointer wrap: pointers wrap modulo p_depth, toggling the wrap bit; count =
//   tail - head including the wrap bit.
// - Reset mid-operation: all entries are discarded; there is no drain.
// CONFIGURATION
// - ISSUE_BYPASS_EN defined:
//   - pend_eff[i] = pend[i] & !(cmp_val & head.psrc[i] == cmp_preg).
//   - The head issues in the same cycle its last operand completes.
// - ISSUE_BYPASS_EN undefined:
//   - pend_eff = pend (registered).
//   - The head issues no earlier than the cycle after the wakeup broadcast.
// TESTING
// - Reset, then enq seq 5 with pend=00 -> deq_val=1 the next cycle, deq_seq_num=5, count=1;
//   deq_rdy=1 -> count=0.
// - Enq 4 entries (seq 1..4), deq_rdy=0 -> count=4, enq_rdy=0; a 5th enq_val is ignored and
//   count stays 4.
// - Head psrc0=7 pend=01; cmp_val=1, cmp_preg=7 at cycle t:
//   - with ISSUE_BYPASS_EN -> deq_val=1 at t;
//   - without -> deq_val=1 at t+1.
// - Entries seq 10,11,12,13; sq_val=1, sq_seq_num=11 -> next cycle count=2; the queue drains
//   10 then 11.
// - Wrap: seq 254,255,0,1 queued (p_seq_num_bits=8); squash at seq 255 -> 0 and 1 killed,
//   count=2.
// - Enq seq 20 with psrc1=3 pend=10 while cmp_val=1, cmp_preg=3 -> entry stored ready;
//   deq_val=1 the next cycle.

Source files
------------

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: in-order issue buffer between rename/decode and execute, with wakeup and squash.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enq_val/enq_rdy           enqueue handshake; enq_payload, enq_seq_num, enq_psrc, enq_pend fields
//   deq_val/deq_rdy           issue handshake; deq_payload, deq_seq_num, deq_psrc show the head entry
//   cmp_val, cmp_preg         completion broadcast clearing matching pending sources
//   sq_val, sq_seq_num        squash of every entry younger than sq_seq_num
//   count                     number of occupied entries
// psrc buses pack source 1 in the upper half and source 0 in the lower half.
// Define ISSUE_BYPASS_EN to let the head issue in the same cycle its last operand completes.
module decode_issue_queue #(
    parameter int p_depth          = 4,
    parameter int p_uop_bits       = 32,
    parameter int p_seq_num_bits   = 8,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enq_val,
    output logic                            enq_rdy,
    input  logic [p_uop_bits-1:0]           enq_payload,
    input  logic [p_seq_num_bits-1:0]       enq_seq_num,
    input  logic [2*p_phys_addr_bits-1:0]   enq_psrc,
    input  logic [1:0]                      enq_pend,
    output logic                            deq_val,
    input  logic                            deq_rdy,
    output logic [p_uop_bits-1:0]           deq_payload,
    output logic [p_seq_num_bits-1:0]       deq_seq_num,
    output logic [2*p_phys_addr_bits-1:0]   deq_psrc,
    input  logic                            cmp_val,
    input  logic [p_phys_addr_bits-1:0]     cmp_preg,
    input  logic                            sq_val,
    input  logic [p_seq_num_bits-1:0]       sq_seq_num,
    output logic [$clog2(p_depth):0]        count
);
    localparam int AW = $clog2(p_depth);
    localparam int PW = AW + 1;
    localparam int RW = p_phys_addr_bits;

    logic [p_uop_bits-1:0]     payload_q [p_depth];
    logic [p_seq_num_bits-1:0] seq_q     [p_depth];
    logic [2*RW-1:0]           psrc_q    [p_depth];
    logic [1:0]                pend_q    [p_depth];
    logic [p_depth-1:0]        valid_q, kill;
    logic [PW-1:0]             head_q, tail_q, n_kill, tail_sq;
    logic [AW-1:0]             head_idx, tail_idx;
    logic                      full, empty, head_killed, enq_do, deq_fire;
    logic [1:0]                head_pend;

    function automatic logic younger(input logic [p_seq_num_bits-1:0] e, input logic [p_seq_num_bits-1:0] s);
        logic [p_seq_num_bits-1:0] d;
        d = e - s;
        return d != '0 && !d[p_seq_num_bits-1];
    endfunction

    function automatic logic [1:0] woken(input logic [2*RW-1:0] psrc, input logic [1:0] pend,
                                         input logic cv, input logic [RW-1:0] cp);
        return pend & ~{cv && psrc[2*RW-1:RW] == cp, cv && psrc[RW-1:0] == cp};
    endfunction

    assign head_idx = head_q[AW-1:0];
    assign count    = tail_q - head_q;
    assign full     = head_idx == tail_q[AW-1:0] && head_q[AW] != tail_q[AW];
    assign empty    = head_q == tail_q;
    assign enq_rdy  = !full;

`ifdef ISSUE_BYPASS_EN
    assign head_pend = woken(psrc_q[head_idx], pend_q[head_idx], cmp_val, cmp_preg);
`else
    assign head_pend = pend_q[head_idx];
`endif

    // Younger entries always sit behind older ones, so the killed set is a suffix
    // and the surviving tail is simply the old tail minus the number killed.
    always_comb begin
        n_kill = '0;
        kill   = '0;
        for (int i = 0; i < p_depth; i++) begin
            kill[i] = sq_val && valid_q[i] && younger(seq_q[i], sq_seq_num);
            n_kill  = n_kill + PW'(kill[i]);
        end
    end

    assign head_killed = kill[head_idx];
    assign deq_val     = !empty && head_pend == 2'b00 && !head_killed;
    assign deq_fire    = deq_val && deq_rdy;
    assign enq_do      = enq_val && enq_rdy && !(sq_val && younger(enq_seq_num, sq_seq_num));
    assign tail_sq     = tail_q - n_kill;
    assign tail_idx    = tail_sq[AW-1:0];

    assign deq_payload = payload_q[head_idx];
    assign deq_seq_num = seq_q[head_idx];
    assign deq_psrc    = psrc_q[head_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q <= head_q + PW'(deq_fire);
            tail_q <= tail_sq + PW'(enq_do);
            for (int i = 0; i < p_depth; i++) begin
                pend_q[i] <= woken(psrc_q[i], pend_q[i], cmp_val, cmp_preg);
                if (kill[i] || (deq_fire && head_idx == AW'(i))) valid_q[i] <= 1'b0;
            end
            if (enq_do) begin
                valid_q[tail_idx]   <= 1'b1;
                payload_q[tail_idx] <= enq_payload;
                seq_q[tail_idx]     <= enq_seq_num;
                psrc_q[tail_idx]    <= enq_psrc;
                pend_q[tail_idx]    <= woken(enq_psrc, enq_pend, cmp_val, cmp_preg);
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: scoreboard bench for decode_issue_queue (default parameters).
module tb_decode_issue_queue;
    localparam int D = 4;
`ifdef ISSUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, enq_val, enq_rdy, deq_val, deq_rdy, cmp_val, sq_val;
    logic [31:0] enq_payload, deq_payload;
    logic [7:0]  enq_seq_num, deq_seq_num, sq_seq_num;
    logic [11:0] enq_psrc, deq_psrc;
    logic [1:0]  enq_pend;
    logic [5:0]  cmp_preg;
    logic [2:0]  count;

    typedef struct {
        logic [7:0]  seq;
        logic [31:0] pay;
        logic [11:0] psrc;
    } ent_t;

    ent_t sb[$];
    int   tests = 0;
    int   fails = 0;

    decode_issue_queue dut (
        .clk(clk), .rst(rst),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_payload(enq_payload),
        .enq_seq_num(enq_seq_num), .enq_psrc(enq_psrc), .enq_pend(enq_pend),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_payload(deq_payload),
        .deq_seq_num(deq_seq_num), .deq_psrc(deq_psrc),
        .cmp_val(cmp_val), .cmp_preg(cmp_preg),
        .sq_val(sq_val), .sq_seq_num(sq_seq_num), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic young(input logic [7:0] e, input logic [7:0] s);
        logic [7:0] d;
        d = e - s;
        return d != 8'd0 && d < 8'd128;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs already driven; advances one cycle.
    task automatic tick();
        int n0;
        n0 = sb.size();
        #1;
        if (rst) sb.delete();
        else begin
            if (deq_val && deq_rdy) begin
                check("deq_underflow", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    check("deq_seq", deq_seq_num, sb[0].seq);
                    check("deq_payload", deq_payload, sb[0].pay);
                    check("deq_psrc", deq_psrc, sb[0].psrc);
                    void'(sb.pop_front());
                end
            end
            if (sq_val)
                while (sb.size() > 0 && young(sb[$].seq, sq_seq_num)) void'(sb.pop_back());
            if (enq_val && n0 < D && !(sq_val && young(enq_seq_num, sq_seq_num)))
                sb.push_back('{enq_seq_num, enq_payload, enq_psrc});
        end
        @(posedge clk);
        #1;
        check("count", count, 64'(sb.size()));
        check("enq_rdy", enq_rdy, 64'(sb.size() < D));
    endtask

    task automatic put(input logic [7:0] s, input logic [1:0] p, input logic [11:0] ps);
        enq_val     = 1'b1;
        enq_seq_num = s;
        enq_pend    = p;
        enq_psrc    = ps;
        enq_payload = $urandom;
        tick();
        enq_val = 1'b0;
    endtask

    task automatic drain();
        deq_rdy = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        deq_rdy = 1'b0;
        check("drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s;
        rst = 1'b1; enq_val = 1'b0; deq_rdy = 1'b0; cmp_val = 1'b0; sq_val = 1'b0;
        enq_payload = '0; enq_seq_num = '0; enq_psrc = '0; enq_pend = '0;
        cmp_preg = '0; sq_seq_num = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", count, 64'd0);
        check("rst_enq_rdy", enq_rdy, 64'd1);
        check("rst_deq_val", deq_val, 64'd0);

        // single entry, one-cycle latency with no flow-through
        enq_val = 1'b1; enq_seq_num = 8'd5; enq_pend = 2'b00; enq_psrc = 12'h041; enq_payload = 32'hdead_0005;
        #1;
        check("t1_no_flow", deq_val, 64'd0);
        tick();
        enq_val = 1'b0;
        check("t1_deq_val", deq_val, 64'd1);
        check("t1_seq", deq_seq_num, 64'd5);
        check("t1_count1", count, 64'd1);
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
        check("t1_count0", count, 64'd0);

        // fill to full; extra enqueue ignored
        for (int i = 1; i <= 4; i++) put(8'(i), 2'b00, 12'($urandom));
        check("t2_full", enq_rdy, 64'd0);
        put(8'd9, 2'b00, 12'h0);
        check("t2_count", count, 64'd4);
        drain();

        // wakeup of the head
        put(8'd30, 2'b01, {6'd12, 6'd7});
        check("t3_pending", deq_val, 64'd0);
        tick();
        check("t3_still", deq_val, 64'd0);
        cmp_val = 1'b1; cmp_preg = 6'd7;
        #1;
        check("t3_bypass", deq_val, 64'(BYP));
        tick();
        cmp_val = 1'b0;
        check("t3_woken", deq_val, 64'd1);
        drain();

        // squash keeps 10, 11
        for (int i = 10; i <= 13; i++) put(8'(i), 2'b00, 12'($urandom));
        sq_val = 1'b1; sq_seq_num = 8'd11;
        tick();
        sq_val = 1'b0;
        check("t4_count", count, 64'd2);
        drain();

        // squash across sequence-number wrap
        put(8'd254, 2'b00, 12'h1); put(8'd255, 2'b00, 12'h2);
        put(8'd0, 2'b00, 12'h3);   put(8'd1, 2'b00, 12'h4);
        sq_val = 1'b1; sq_seq_num = 8'd255;
        tick();
        sq_val = 1'b0;
        check("t5_count", count, 64'd2);
        drain();

        // wakeup while enqueuing
        cmp_val = 1'b1; cmp_preg = 6'd3;
        put(8'd20, 2'b10, {6'd3, 6'd9});
        cmp_val = 1'b0;
        check("t6_ready", deq_val, 64'd1);
        drain();

        // head killed blocks issue
        put(8'd40, 2'b00, 12'h5); put(8'd41, 2'b00, 12'h6);
        sq_val = 1'b1; sq_seq_num = 8'd39; deq_rdy = 1'b1;
        #1;
        check("t7_head_killed", deq_val, 64'd0);
        tick();
        sq_val = 1'b0; deq_rdy = 1'b0;
        check("t7_count", count, 64'd0);

        // dequeue completes alongside a squash of younger entries
        put(8'd60, 2'b00, 12'h7); put(8'd61, 2'b00, 12'h8); put(8'd62, 2'b00, 12'h9);
        sq_val = 1'b1; sq_seq_num = 8'd60; deq_rdy = 1'b1;
        tick();
        sq_val = 1'b0; deq_rdy = 1'b0;
        check("t8_count", count, 64'd0);

        // enqueue with squash: younger dropped, older kept
        put(8'd70, 2'b00, 12'ha);
        sq_val = 1'b1; sq_seq_num = 8'd70;
        put(8'd71, 2'b00, 12'hb);
        put(8'd69, 2'b00, 12'hc);
        sq_val = 1'b0;
        check("t9_count", count, 64'd2);
        drain();

        // simultaneous enq + deq keeps count
        put(8'd80, 2'b00, 12'hd); put(8'd81, 2'b00, 12'he);
        deq_rdy = 1'b1;
        put(8'd82, 2'b00, 12'hf);
        deq_rdy = 1'b0;
        check("t10_count", count, 64'd2);
        drain();

        // random traffic
        s = 8'd100;
        for (int i = 0; i < 60; i++) begin
            enq_val = 1'($urandom_range(0, 1)); deq_rdy = 1'($urandom_range(0, 1));
            enq_seq_num = s; enq_pend = 2'b00; enq_psrc = 12'($urandom); enq_payload = $urandom;
            if (enq_val && enq_rdy) s = s + 8'd1;
            tick();
        end
        enq_val = 1'b0;
        drain();

        // reset mid-operation
        put(8'd90, 2'b00, 12'h1); put(8'd91, 2'b00, 12'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t12_count", count, 64'd0);
        check("t12_deq_val", deq_val, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
